regfile_seq_gen: RTL and testbench

Parametrised register file that fills itself with a generated sequence and then serves multi-port reads. It replaces the fixed 64x64 Fibonacci-fill register file. It adds configurable width, depth and read-port count, selectable sequence modes, host-supplied seeds, restart on demand, and a sticky overflow flag. It sits under the lab top level as the storage and sequence engine the testbench reads back.

---
 rtl/regfile_seq_pkg.sv | 19 +
 rtl/regfile_mport.sv | 45 ++++
 rtl/regfile_seq_gen.sv | 155 +++++++++++++++
 tb/tb_regfile_seq_gen.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_seq_pkg.sv
// Shared encodings for the self-filling register file: sequence modes,
// controller states and the seeds used for the automatic post-reset fill.
package regfile_seq_pkg;

  localparam logic [1:0] MODE_FIB   = 2'd0;
  localparam logic [1:0] MODE_ARITH = 2'd1;
  localparam logic [1:0] MODE_CONST = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } seqState_t;

  localparam logic [1:0] AUTO_MODE  = MODE_FIB;
  localparam int         AUTO_SEED0 = 0;
  localparam int         AUTO_SEED1 = 1;

endpackage

// File: rtl/regfile_mport.sv
// DEPTH x WIDTH storage: one synchronous write port, NUM_RD combinational
// read ports, whole array cleared by the asynchronous reset.
module regfile_mport #(
  parameter int WIDTH  = 64,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wrAddr,
  input  logic [WIDTH-1:0]         wrData,
  input  logic [NUM_RD*ADDR_W-1:0] rdAddr,
  output logic [NUM_RD*WIDTH-1:0]  rdData
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wrAddr] <= wrData;
    end
  end

  // Out-of-range addresses read as zero so a non-power-of-two DEPTH stays safe.
  logic [ADDR_W-1:0] rdA;
  always_comb begin
    rdData = '0;
    rdA    = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rdA = rdAddr[p*ADDR_W +: ADDR_W];
      if ({1'b0, rdA} < DEPTH_L) begin
        rdData[p*WIDTH +: WIDTH] = mem[rdA];
      end
    end
  end

endmodule

// File: rtl/regfile_seq_gen.sv
// Register file that fills itself with a FIB, ARITH or CONST sequence after
// an accepted start (or automatically after reset) and then serves reads.
module regfile_seq_gen
  import regfile_seq_pkg::*;
#(
  parameter  int WIDTH      = 64,
  parameter  int DEPTH      = 64,
  localparam int ADDR_W     = $clog2(DEPTH),
  parameter  int NUM_RD     = 2,
  parameter  int AUTO_START = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic [WIDTH-1:0]         seed0,
  input  logic [WIDTH-1:0]         seed1,
  output logic                     busy,
  output logic                     ready,
  output logic                     overflow,
  output logic [ADDR_W-1:0]        fill_idx,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*WIDTH-1:0]  rd_data
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  seqState_t         state, stateNext;
  logic              autoPend;
  logic [1:0]        capMode;
  logic [WIDTH-1:0]  capSeed0, capSeed1;
  logic [WIDTH-1:0]  prevA, prevB;
  logic [ADDR_W-1:0] fillIdx;
  logic              ovfReg;

  logic              accept;
  logic [1:0]        accMode;
  logic [WIDTH-1:0]  accSeed0, accSeed1;
  logic [WIDTH:0]    sum;
  logic [WIDTH-1:0]  genVal;
  logic              genCarry;
  logic              lastIdx;
  logic              writeEn;

  function automatic logic [WIDTH:0] addWithCarry(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // The auto-start edge overrides whatever is on the external start inputs.
  always_comb begin
    accept   = autoPend || (start && (state != ST_FILL));
    accMode  = autoPend ? AUTO_MODE : mode;
    accSeed0 = autoPend ? WIDTH'(AUTO_SEED0) : seed0;
    accSeed1 = autoPend ? WIDTH'(AUTO_SEED1) : seed1;
  end

  // prevA holds r(i-1) and prevB holds r(i-2) for the entry being written.
  always_comb begin
    sum      = addWithCarry(prevA, (capMode == MODE_ARITH) ? capSeed1 : prevB);
    genVal   = capSeed0;
    genCarry = 1'b0;
    case (capMode)
      MODE_FIB: begin
        if (fillIdx == '0) begin
          genVal = capSeed0;
        end else if (fillIdx == ADDR_W'(1)) begin
          genVal = capSeed1;
        end else begin
          genVal   = sum[WIDTH-1:0];
          genCarry = sum[WIDTH];
        end
      end
      MODE_ARITH: begin
        if (fillIdx != '0) begin
          genVal   = sum[WIDTH-1:0];
          genCarry = sum[WIDTH];
        end
      end
      default: genVal = capSeed0;
    endcase
  end

  assign lastIdx = (fillIdx == LAST_IDX);
  assign writeEn = (state == ST_FILL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept) stateNext = ST_FILL;
      end
      ST_FILL: begin
        if (lastIdx) stateNext = ST_DONE;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      autoPend <= (AUTO_START != 0);
      capMode  <= '0;
      capSeed0 <= '0;
      capSeed1 <= '0;
      prevA    <= '0;
      prevB    <= '0;
      fillIdx  <= '0;
      ovfReg   <= 1'b0;
    end else begin
      autoPend <= 1'b0;
      if (accept) begin
        capMode  <= accMode;
        capSeed0 <= accSeed0;
        capSeed1 <= accSeed1;
        fillIdx  <= '0;
        ovfReg   <= 1'b0;
      end else if (writeEn) begin
        prevB   <= prevA;
        prevA   <= genVal;
        ovfReg  <= ovfReg | genCarry;
        fillIdx <= lastIdx ? '0 : fillIdx + ADDR_W'(1);
      end
    end
  end

  regfile_mport #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .NUM_RD(NUM_RD)
  ) uStore (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (writeEn),
    .wrAddr(fillIdx),
    .wrData(genVal),
    .rdAddr(rd_addr),
    .rdData(rd_data)
  );

  assign busy     = (state == ST_FILL);
  assign ready    = (state == ST_DONE);
  assign overflow = ovfReg;
  assign fill_idx = fillIdx;

endmodule

// File: tb/tb_regfile_seq_gen.sv
// Bench for regfile_seq_gen: a default 64x64 instance and a small 8-bit x 16
// instance, table vectors, random fills against a sequence model, corner cases.
module tb_regfile_seq_gen;
  import regfile_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  mode;
  logic [63:0] seed0, seed1;
  logic        busy, ready, overflow;
  logic [5:0]  fillIdx;
  logic [11:0] rdAddr;
  logic [127:0] rdData;

  logic        startS;
  logic [1:0]  modeS;
  logic [7:0]  seed0S, seed1S;
  logic        busyS, readyS, overflowS;
  logic [3:0]  fillIdxS;
  logic [7:0]  rdAddrS;
  logic [15:0] rdDataS;

  int errors = 0;
  int checks = 0;

  logic [63:0] modelMem [64];
  logic        modelOvf;

  typedef struct {
    logic [1:0]  m;
    logic [63:0] s0;
    logic [63:0] s1;
    int          addr;
    logic [63:0] expData;
    logic        expOvf;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  regfile_seq_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .seed0(seed0), .seed1(seed1), .busy(busy), .ready(ready),
    .overflow(overflow), .fill_idx(fillIdx), .rd_addr(rdAddr), .rd_data(rdData)
  );

  regfile_seq_gen #(.WIDTH(8), .DEPTH(16), .NUM_RD(2), .AUTO_START(1)) dutS (
    .clk(clk), .rst_n(rst_n), .start(startS), .mode(modeS),
    .seed0(seed0S), .seed1(seed1S), .busy(busyS), .ready(readyS),
    .overflow(overflowS), .fill_idx(fillIdxS), .rd_addr(rdAddrS), .rd_data(rdDataS)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Whole sequence from the mode rules, with a 65-bit sum to see wrap-around.
  task automatic modelFill(input logic [1:0] m, input logic [63:0] s0, input logic [63:0] s1);
    logic [64:0] wide;
    modelOvf = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (m == MODE_FIB && i >= 2) begin
        wide = {1'b0, modelMem[i-1]} + {1'b0, modelMem[i-2]};
        modelMem[i] = wide[63:0];
        modelOvf |= wide[64];
      end else if (m == MODE_ARITH && i >= 1) begin
        wide = {1'b0, modelMem[i-1]} + {1'b0, s1};
        modelMem[i] = wide[63:0];
        modelOvf |= wide[64];
      end else if (m == MODE_FIB && i == 1) begin
        modelMem[i] = s1;
      end else begin
        modelMem[i] = s0;
      end
    end
  endtask

  task automatic checkAll(input string name);
    for (int a = 0; a < 64; a++) begin
      rdAddr = {6'($urandom_range(0, 63)), 6'(a)};
      #1;
      check({name, " port0"}, rdData[63:0], modelMem[rdAddr[5:0]]);
      check({name, " port1"}, rdData[127:64], modelMem[rdAddr[11:6]]);
    end
  endtask

  task automatic accept(input logic [1:0] m, input logic [63:0] s0, input logic [63:0] s1,
                        input string name);
    @(negedge clk);
    start = 1'b1; mode = m; seed0 = s0; seed1 = s1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({name, " busy after accept"}, 64'(busy), 64'd1);
    check({name, " ready after accept"}, 64'(ready), 64'd0);
    check({name, " overflow after accept"}, 64'(overflow), 64'd0);
    check({name, " fill_idx after accept"}, 64'(fillIdx), 64'd0);
    modelFill(m, s0, s1);
  endtask

  task automatic waitReady(input int expLat, input string name);
    int lat;
    lat = 0;
    while (!ready && lat < 300) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'(expLat));
  endtask

  initial begin
    int firstReady, firstOvfS, guard;
    logic [63:0] expP0, expP1;

    vecs[0] = '{MODE_ARITH, 64'd5, 64'd3, 63, 64'd194, 1'b0};
    vecs[1] = '{MODE_ARITH, 64'd5, 64'd3, 10, 64'd35, 1'b0};
    vecs[2] = '{MODE_CONST, 64'hAA, 64'd9, 37, 64'hAA, 1'b0};
    vecs[3] = '{MODE_FIB, 64'd0, 64'd1, 50, 64'd12586269025, 1'b0};
    vecs[4] = '{MODE_ARITH, 64'd0, 64'h8000_0000_0000_0000, 3, 64'h8000_0000_0000_0000, 1'b1};
    vecs[5] = '{2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd7, 7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[6] = '{MODE_FIB, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2, 64'd0, 1'b1};

    rst_n = 1'b0; start = 1'b0; mode = 2'd0; seed0 = '0; seed1 = '0; rdAddr = {6'd9, 6'd1};
    startS = 1'b0; modeS = 2'd2; seed0S = 8'h55; seed1S = '0; rdAddrS = {4'd14, 4'd13};

    // Reset state, then auto-start FIB on both instances.
    #50;
    check("reset busy", 64'(busy), 64'd0);
    check("reset ready", 64'(ready), 64'd0);
    check("reset overflow", 64'(overflow), 64'd0);
    check("reset fill_idx", 64'(fillIdx), 64'd0);
    check("reset rd_data", rdData[63:0] | rdData[127:64], 64'd0);
    check("reset small rd_data", 64'(rdDataS), 64'd0);
    #50;
    rst_n = 1'b1;
    firstReady = -1; firstOvfS = -1;
    for (int k = 0; k <= 70; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 0) begin
        check("auto busy", 64'(busy), 64'd1);
        check("auto fill_idx E0", 64'(fillIdx), 64'd0);
      end
      if (k == 1) check("auto fill_idx E1", 64'(fillIdx), 64'd1);
      if (ready && firstReady < 0) firstReady = k;
      if (overflowS && firstOvfS < 0) firstOvfS = k;
    end
    check("auto ready latency", 64'(firstReady), 64'd64);
    check("small overflow edge", 64'(firstOvfS), 64'd15);
    check("small overflow sticky", 64'(overflowS), 64'd1);
    check("small ready", 64'(readyS), 64'd1);
    check("small r13", 64'(rdDataS[7:0]), 64'd233);
    check("small r14", 64'(rdDataS[15:8]), 64'd121);
    check("auto overflow", 64'(overflow), 64'd0);
    rdAddr = {6'd63, 6'd2};
    #1;
    check("fib r2", rdData[63:0], 64'd1);
    check("fib r63", rdData[127:64], 64'd6557470319842);
    modelFill(MODE_FIB, 64'd0, 64'd1);
    check("model fib r63", modelMem[63], rdData[127:64]);
    checkAll("auto fib");

    // Table-driven fills started from DONE.
    for (int v = 0; v < 7; v++) begin
      accept(vecs[v].m, vecs[v].s0, vecs[v].s1, $sformatf("vec%0d", v));
      waitReady(64, $sformatf("vec%0d", v));
      rdAddr = {6'd0, 6'(vecs[v].addr)};
      #1;
      check($sformatf("vec%0d data", v), rdData[63:0], vecs[v].expData);
      check($sformatf("vec%0d overflow", v), 64'(overflow), 64'(vecs[v].expOvf));
      checkAll($sformatf("vec%0d", v));
    end

    // Random modes and seeds against the model.
    for (int r = 0; r < 4; r++) begin
      logic [1:0]  rm;
      logic [63:0] rs0, rs1;
      rm  = 2'($urandom_range(0, 3));
      rs0 = {$urandom, $urandom};
      rs1 = {$urandom, $urandom};
      accept(rm, rs0, rs1, $sformatf("rand%0d", r));
      waitReady(64, $sformatf("rand%0d", r));
      check($sformatf("rand%0d overflow", r), 64'(overflow), 64'(modelOvf));
      checkAll($sformatf("rand%0d", r));
    end

    // start while busy must not disturb the running fill.
    accept(MODE_FIB, 64'd0, 64'd1, "midstart");
    guard = 0;
    while (fillIdx != 6'd20 && guard < 100) begin
      @(posedge clk);
      @(negedge clk);
      guard++;
    end
    check("midstart reach idx20", 64'(fillIdx), 64'd20);
    start = 1'b1; mode = MODE_CONST; seed0 = 64'hAA;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("midstart busy", 64'(busy), 64'd1);
    check("midstart fill_idx", 64'(fillIdx), 64'd21);
    waitReady(43, "midstart");
    checkAll("midstart fib");
    accept(MODE_CONST, 64'hAA, 64'd0, "const after");
    waitReady(64, "const after");
    checkAll("const after");

    // Reset in the middle of an overflowing fill.
    accept(MODE_ARITH, 64'd0, 64'h8000_0000_0000_0000, "abort");
    guard = 0;
    while (fillIdx != 6'd30 && guard < 100) begin
      @(posedge clk);
      @(negedge clk);
      guard++;
    end
    check("abort reach idx30", 64'(fillIdx), 64'd30);
    check("abort overflow before", 64'(overflow), 64'(modelOvf));
    rdAddr = {6'd20, 6'd3};
    rst_n = 1'b0;
    #1;
    check("abort rd_data", rdData[63:0] | rdData[127:64], 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    check("abort ready", 64'(ready), 64'd0);
    check("abort overflow", 64'(overflow), 64'd0);
    check("abort fill_idx", 64'(fillIdx), 64'd0);
    @(negedge clk);
    @(negedge clk);

    // Restarted FIB fill with both ports watching entries 5 then 40.
    modelFill(MODE_FIB, 64'd0, 64'd1);
    rdAddr = {6'd5, 6'd5};
    rst_n = 1'b1;
    firstReady = -1;
    for (int n = 0; n <= 70; n++) begin
      @(posedge clk);
      @(negedge clk);
      expP0 = (n > 5) ? modelMem[5] : 64'd0;
      check($sformatf("port0 addr5 n%0d", n), rdData[63:0], expP0);
      if (n <= 10) begin
        check($sformatf("port1 addr5 n%0d", n), rdData[127:64], expP0);
      end else begin
        expP1 = (n > 40) ? modelMem[40] : 64'd0;
        check($sformatf("port1 addr40 n%0d", n), rdData[127:64], expP1);
      end
      if (n == 10) rdAddr = {6'd40, 6'd5};
      if (ready && firstReady < 0) firstReady = n;
    end
    check("restart ready latency", 64'(firstReady), 64'd64);
    check("restart overflow", 64'(overflow), 64'd0);
    checkAll("restart fib");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
